// File: rtl/best_d_pkg.sv
// best_d_pkg: shared constants for the best-divisor pipeline.
//   LN2_Q16   : ln(2) in Q16 fixed point
//   *_W_DEF   : default port widths for best_d
//   LATENCY   : cycles from an input edge to the matching output edge
package best_d_pkg;

  localparam int unsigned LN2_Q16   = 45426;

  localparam int unsigned N_W_DEF   = 11;
  localparam int unsigned T_W_DEF   = 6;
  localparam int unsigned D_W_DEF   = 10;
  localparam int unsigned U_W_DEF   = 4;

  localparam int unsigned LATENCY   = 4;

endpackage

// File: rtl/best_d_div.sv
// best_d_div: combinational unsigned restoring divider, quo_c = floor(num / den).
// Ports:
//   num   : dividend, NUM_W bits
//   den   : divisor, DEN_W bits (den = 0 yields all-ones quotient)
//   quo_c : quotient, NUM_W bits, combinational
module best_d_div #(
  parameter int unsigned NUM_W = 29,
  parameter int unsigned DEN_W = 24
) (
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic [NUM_W-1:0] quo_c
);

  logic [DEN_W:0] rem;

  // One restoring step per dividend bit, MSB first; rem stays below den after each step.
  always_comb begin
    rem   = '0;
    quo_c = '0;
    for (int i = int'(NUM_W) - 1; i >= 0; i--) begin
      rem = {rem[DEN_W-1:0], num[i]};
      if (rem >= {1'b0, den}) begin
        rem      = rem - {1'b0, den};
        quo_c[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/best_d.sv
// best_d: fully pipelined best-divisor calculator.
//   d = clamp(round(ln2 * (n - (t-1)/2) / t), 1, 2^D_W-1), d = 0 when t = 0,
//   u = ceil(log2(d)). One (n,t) pair accepted per cycle, result after edge k+LATENCY.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, clears every stage and the outputs
//   n   : code length (unsigned)
//   t   : code weight (unsigned)
//   d   : registered best divisor
//   u   : registered ceil(log2(d))
module best_d
  import best_d_pkg::*;
#(
  parameter int unsigned N_W = N_W_DEF,
  parameter int unsigned T_W = T_W_DEF,
  parameter int unsigned D_W = D_W_DEF,
  parameter int unsigned U_W = U_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N_W-1:0] n,
  input  logic [T_W-1:0] t,
  output logic [D_W-1:0] d,
  output logic [U_W-1:0] u
);

  // S = 2n - t + 1 needs one bit for the doubling and one for the sign.
  localparam int unsigned S_W   = N_W + 2;
  localparam int unsigned MAG_W = S_W - 1;
  // LN2_Q16 * S < 2^(N_W+17); adding t*2^16 stays below 2^(N_W+18).
  localparam int unsigned NUM_W = N_W + 18;
  localparam int unsigned DEN_W = T_W + 18;
  localparam int unsigned P_W   = D_W + 1;
  localparam int unsigned D_MAX = (1 << D_W) - 1;

  // Stage 1: input capture
  logic           v1;
  logic [N_W-1:0] n1;
  logic [T_W-1:0] t1;

  // Stage 2: signed S
  logic                  v2;
  logic signed [S_W-1:0] s2;
  logic [T_W-1:0]        t2;
  logic [S_W-1:0]        s_c;

  // Stage 3: dividend / divisor and case flags
  logic             v3, pos3, tz3;
  logic [NUM_W-1:0] num3;
  logic [DEN_W-1:0] den3;
  logic             pos_c;
  logic [MAG_W-1:0] mag_c;
  logic [NUM_W-1:0] num_c;

  // Stage 4: quotient
  logic             v4, pos4, tz4;
  logic [NUM_W-1:0] q4;
  logic [NUM_W-1:0] quo_c;

  // Stage 5 combinational results
  logic [D_W-1:0] d_c;
  logic [U_W-1:0] u_c;
  logic [P_W-1:0] pow_c;

  // Unsigned modular arithmetic gives the correct two's-complement S.
  assign s_c   = S_W'({n1, 1'b0}) - S_W'(t1) + S_W'(1);

  assign pos_c = !s2[S_W-1] && (s2 != '0);
  assign mag_c = s2[MAG_W-1:0];
  assign num_c = NUM_W'(LN2_Q16) * NUM_W'(mag_c) + (NUM_W'(t2) << 16);

  best_d_div #(
    .NUM_W (NUM_W),
    .DEN_W (DEN_W)
  ) u_div (
    .num   (num3),
    .den   (den3),
    .quo_c (quo_c)
  );

  // Clamp quotient into 1..D_MAX; special cases for non-positive S and t = 0.
  always_comb begin
    d_c = '0;
    if (!v4 || tz4) begin
      d_c = '0;
    end else if (!pos4 || (q4 == '0)) begin
      d_c = D_W'(1);
    end else if (q4 > NUM_W'(D_MAX)) begin
      d_c = D_W'(D_MAX);
    end else begin
      d_c = D_W'(q4);
    end
  end

  // Priority encoder: scan down so the last hit is the smallest u with 2^u >= d.
  always_comb begin
    u_c   = '0;
    pow_c = '0;
    for (int i = int'(D_W); i >= 0; i--) begin
      pow_c = P_W'(1) << i;
      if (pow_c >= {1'b0, d_c}) begin
        u_c = U_W'(i);
      end
    end
  end

  // Pipeline registers; v* marks stages holding a real sampled pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      n1   <= '0;
      t1   <= '0;
      v2   <= 1'b0;
      s2   <= '0;
      t2   <= '0;
      v3   <= 1'b0;
      pos3 <= 1'b0;
      tz3  <= 1'b0;
      num3 <= '0;
      den3 <= '0;
      v4   <= 1'b0;
      pos4 <= 1'b0;
      tz4  <= 1'b0;
      q4   <= '0;
      d    <= '0;
      u    <= '0;
    end else begin
      v1   <= 1'b1;
      n1   <= n;
      t1   <= t;

      v2   <= v1;
      s2   <= s_c;
      t2   <= t1;

      v3   <= v2;
      pos3 <= pos_c;
      tz3  <= (t2 == '0);
      num3 <= pos_c ? num_c : '0;
      den3 <= DEN_W'(t2) << 17;

      v4   <= v3;
      pos4 <= pos3;
      tz4  <= tz3;
      q4   <= quo_c;

      d    <= d_c;
      u    <= (!v4 || tz4) ? '0 : u_c;
    end
  end

endmodule

// File: tb/tb_best_d.sv
// tb_best_d: directed-vector bench for best_d with a formula-level reference model
// and literal expectations at fixed cycles.
module tb_best_d;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] n   = '0;
  logic [5:0]  t   = '0;
  logic [9:0]  d;
  logic [3:0]  u;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  // Expected-result history, newest at index 0; index 4 is what shows after this edge.
  bit hv[5];
  int hd[5];
  int hu[5];

  // Literal expectations keyed by the edge count after which they must hold.
  int lit_d[int];
  int lit_u[int];

  best_d dut (
    .clk (clk),
    .rst (rst),
    .n   (n),
    .t   (t),
    .d   (d),
    .u   (u)
  );

  always #5 clk = ~clk;

  function automatic int model_d(input int nn, input int tt);
    longint s, q;
    if (tt == 0) return 0;
    s = 2 * longint'(nn) - longint'(tt) + 1;
    if (s <= 0) return 1;
    q = (45426 * s + longint'(tt) * 65536) / (longint'(tt) * 131072);
    if (q < 1) q = 1;
    if (q > 1023) q = 1023;
    return int'(q);
  endfunction

  function automatic int model_u(input int dd);
    int k;
    k = 0;
    while ((1 << k) < dd) k++;
    return k;
  endfunction

  // Reference model: record what each sampled pair must produce.
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (rst) begin
        for (int i = 0; i < 5; i++) hv[i] = 1'b0;
      end else begin
        for (int i = 4; i > 0; i--) begin
          hv[i] = hv[i-1];
          hd[i] = hd[i-1];
          hu[i] = hu[i-1];
        end
        hv[0] = 1'b1;
        hd[0] = model_d(int'(n), int'(t));
        hu[0] = model_u(hd[0]);
      end
    end
  end

  // Compare process: model every cycle, plus any literal due this cycle.
  initial begin
    forever begin
      int ed, eu;
      @(negedge clk);
      if (cyc > 0) begin
        ed = hv[4] ? hd[4] : 0;
        eu = hv[4] ? hu[4] : 0;
        tests++;
        if (d !== 10'(ed) || u !== 4'(eu)) begin
          fails++;
          $display("FAIL model cyc=%0d got d=%0d u=%0d expected d=%0d u=%0d", cyc, d, u, ed, eu);
        end
        if (lit_d.exists(cyc)) begin
          tests++;
          if (d !== 10'(lit_d[cyc]) || u !== 4'(lit_u[cyc])) begin
            fails++;
            $display("FAIL literal cyc=%0d got d=%0d u=%0d expected d=%0d u=%0d",
                     cyc, d, u, lit_d[cyc], lit_u[cyc]);
          end
        end
      end
    end
  end

  // Apply one pair (and rst) for exactly one sampling edge.
  task automatic go(input int nn, input int tt, input bit r);
    n   = 11'(nn);
    t   = 6'(tt);
    rst = r;
    @(posedge clk);
    #1;
  endtask

  // Expect (ed,eu) after the edge lat cycles past the next sampling edge.
  task automatic expect_at(input int lat, input int ed, input int eu);
    lit_d[cyc + 1 + lat] = ed;
    lit_u[cyc + 1 + lat] = eu;
  endtask

  typedef struct {
    int nn;
    int tt;
    int ed;
    int eu;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{1024,  1,  710, 10};
    vecs[1]  = '{1024,  2,  355,  9};
    vecs[2]  = '{1024,  3,  236,  8};
    vecs[3]  = '{1024, 10,   71,  7};
    vecs[4]  = '{1024, 38,   18,  5};
    vecs[5]  = '{2047,  1, 1023, 10};
    vecs[6]  = '{   0,  5,    1,  0};
    vecs[7]  = '{ 500,  0,    0,  0};
    vecs[8]  = '{2047,  0,    0,  0};
    vecs[9]  = '{2047, 63,   22,  5};
    vecs[10] = '{  31, 63,    1,  0};
    vecs[11] = '{   3,  5,    1,  0};
    vecs[12] = '{2047,  2,  709, 10};

    // Reset state
    expect_at(0, 0, 0);
    go(0, 0, 1);
    go(0, 0, 1);
    go(0, 0, 1);

    // Outputs stay 0 until the first pair arrives four edges after sampling
    for (int k = 0; k < 4; k++) expect_at(k, 0, 0);
    expect_at(4, 710, 10);
    go(1024, 1, 0);
    for (int k = 0; k < 4; k++) go(1024, 1, 0);

    // Directed vectors back to back
    for (int i = 0; i < 13; i++) begin
      expect_at(4, vecs[i].ed, vecs[i].eu);
      go(vecs[i].nn, vecs[i].tt, 0);
    end

    // t = 1..38 on consecutive cycles
    for (int k = 1; k <= 38; k++) go(1024, k, 0);

    // Mixed pairs
    for (int k = 0; k < 40; k++) go(int'($urandom_range(0, 2047)), int'($urandom_range(0, 63)), 0);

    // Mid-stream reset drops everything in flight
    go(1500, 7, 0);
    go(1500, 8, 0);
    expect_at(0, 0, 0);
    go(100, 9, 1);
    for (int k = 0; k < 4; k++) expect_at(k, 0, 0);
    expect_at(4, 355, 9);
    go(1024, 2, 0);
    expect_at(4, 236, 8);
    go(1024, 3, 0);
    for (int k = 0; k < 8; k++) go(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
